// File: rtl/apple_placer_if.sv
// Signal bundle between the apple placer and its game-side neighbours
// (generator, body RAM, head tracker and display/collision logic).
interface apple_placer_if #(
    parameter int unsigned IDX_W = 5
);
    logic             game_start;
    logic             game_over;
    logic             tick;
    logic [4:0]       head_x;
    logic [4:0]       head_y;
    logic [IDX_W:0]   snake_len;
    logic [4:0]       cand_x;
    logic [4:0]       cand_y;
    logic             apple_valid;
    logic             apple_conflict;
    logic [IDX_W-1:0] seg_idx;
    logic [4:0]       seg_x;
    logic [4:0]       seg_y;
    logic [4:0]       apple_x;
    logic [4:0]       apple_y;
    logic             apple_ready;
    logic             apple_eaten;
    logic             place_fail;
    logic [7:0]       score;

    modport master (
        input  game_start, game_over, tick, head_x, head_y, snake_len,
               cand_x, cand_y, seg_x, seg_y,
        output apple_valid, apple_conflict, seg_idx, apple_x, apple_y,
               apple_ready, apple_eaten, place_fail, score
    );

    modport slave (
        output game_start, game_over, tick, head_x, head_y, snake_len,
               cand_x, cand_y, seg_x, seg_y,
        input  apple_valid, apple_conflict, seg_idx, apple_x, apple_y,
               apple_ready, apple_eaten, place_fail, score
    );
endinterface

// File: rtl/apple_placer.sv
// Apple placement FSM: fetches a candidate, rejects it when it lands on the snake body
// or off the playfield, commits it otherwise, then scores eats sampled on tick.
module apple_placer #(
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned Y_MAX     = 24,
    parameter int unsigned MAX_RETRY = 15
) (
    input logic            clk,
    input logic            rst,
    apple_placer_if.master bus
);
    localparam int unsigned CW = 5;
    localparam int unsigned LW = IDX_W + 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam int unsigned SW = 8;
    localparam logic [CW-1:0] RST_X = CW'(8);
    localparam logic [CW-1:0] RST_Y = CW'(16);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SCAN, PLACED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [LW-1:0]   len_q, len_d, k_q, k_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [CW-1:0]   apple_x_q, apple_x_d, apple_y_q, apple_y_d;
    logic            ready_q, ready_d;
    logic            eaten_q, eaten_d;
    logic            fail_q, fail_d;
    logic [SW-1:0]   score_q, score_d;
    logic            valid_c, conflict_c, hit_c;
    logic [IDX_W-1:0] seg_idx_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            len_q     <= '0;
            k_q       <= '0;
            retry_q   <= '0;
            apple_x_q <= RST_X;
            apple_y_q <= RST_Y;
            ready_q   <= 1'b0;
            eaten_q   <= 1'b0;
            fail_q    <= 1'b0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            len_q     <= len_d;
            k_q       <= k_d;
            retry_q   <= retry_d;
            apple_x_q <= apple_x_d;
            apple_y_q <= apple_y_d;
            ready_q   <= ready_d;
            eaten_q   <= eaten_d;
            fail_q    <= fail_d;
            score_q   <= score_d;
        end
    end

    // Body data for index k-1 arrives in cycle k, so compares start at k=1.
    always_comb begin
        state_d    = state_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        len_d      = len_q;
        k_d        = k_q;
        retry_d    = retry_q;
        apple_x_d  = apple_x_q;
        apple_y_d  = apple_y_q;
        ready_d    = ready_q;
        eaten_d    = 1'b0;
        fail_d     = fail_q;
        score_d    = score_q;
        valid_c    = 1'b0;
        conflict_c = 1'b0;
        hit_c      = 1'b0;
        seg_idx_c  = '0;

        if (bus.game_over) begin
            state_d = IDLE;
            ready_d = 1'b0;
        end else if (bus.game_start) begin
            state_d = REQ;
            score_d = '0;
            fail_d  = 1'b0;
            retry_d = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                REQ: begin
                    valid_c = 1'b1;
                    ready_d = 1'b0;
                    state_d = WAIT;
                end
                WAIT: begin
                    cand_x_d = bus.cand_x;
                    cand_y_d = bus.cand_y;
                    len_d    = (bus.snake_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : bus.snake_len;
                    k_d      = '0;
                    state_d  = SCAN;
                end
                SCAN: begin
                    if (k_q < len_q) seg_idx_c = k_q[IDX_W-1:0];
                    hit_c = (cand_y_q >= CW'(Y_MAX)) ||
                            ((k_q != '0) && (bus.seg_x == cand_x_q) && (bus.seg_y == cand_y_q));
                    if (hit_c) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d    = retry_q + RW'(1);
                            conflict_c = 1'b1;
                            state_d    = WAIT;
                        end else begin
                            fail_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (k_q == len_q) begin
                        apple_x_d = cand_x_q;
                        apple_y_d = cand_y_q;
                        ready_d   = 1'b1;
                        retry_d   = '0;
                        state_d   = PLACED;
                    end else begin
                        k_d = k_q + LW'(1);
                    end
                end
                PLACED: begin
                    if (bus.tick && (bus.head_x == apple_x_q) && (bus.head_y == apple_y_q)) begin
                        eaten_d = 1'b1;
                        if (score_q != '1) score_d = score_q + SW'(1);
                        ready_d = 1'b0;
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.apple_valid    = valid_c;
    assign bus.apple_conflict = conflict_c;
    assign bus.seg_idx        = seg_idx_c;
    assign bus.apple_x        = apple_x_q;
    assign bus.apple_y        = apple_y_q;
    assign bus.apple_ready    = ready_q;
    assign bus.apple_eaten    = eaten_q;
    assign bus.place_fail     = fail_q;
    assign bus.score          = score_q;
endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer with a queue-driven candidate generator and a
// one-cycle-latency body RAM model.
module tb_apple_placer;
    localparam int unsigned IDX_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    apple_placer_if #(.IDX_W(IDX_W)) bus ();

    apple_placer #(.MAX_LEN(32), .IDX_W(IDX_W), .Y_MAX(24), .MAX_RETRY(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] body_x [32];
    logic [4:0] body_y [32];
    logic [4:0] q_x [$];
    logic [4:0] q_y [$];
    logic [4:0] dflt_x, dflt_y;
    int         n_valid = 0;
    int         n_conf  = 0;

    // Body RAM and candidate generator models.
    always @(posedge clk) begin
        bus.seg_x <= body_x[bus.seg_idx];
        bus.seg_y <= body_y[bus.seg_idx];
        if (bus.apple_valid || bus.apple_conflict) begin
            if (q_x.size() > 0) begin
                bus.cand_x <= q_x.pop_front();
                bus.cand_y <= q_y.pop_front();
            end else begin
                bus.cand_x <= dflt_x;
                bus.cand_y <= dflt_y;
            end
        end
        if (bus.apple_valid)    n_valid++;
        if (bus.apple_conflict) n_conf++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] x, input logic [4:0] y);
        q_x.push_back(x);
        q_y.push_back(y);
    endtask

    // Ends in the REQ cycle.
    task automatic start_game();
        bus.game_start = 1'b1;
        cyc();
        bus.game_start = 1'b0;
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int i = 0;
        while (bus.apple_ready !== 1'b1 && i < budget) begin
            cyc();
            i++;
        end
        chk(tag, 32'(bus.apple_ready), 32'd1);
    endtask

    initial begin
        int c0, v0, eats, i;
        rst            = 1'b0;
        bus.game_start = 1'b0;
        bus.game_over  = 1'b0;
        bus.tick       = 1'b0;
        bus.head_x     = '0;
        bus.head_y     = '0;
        bus.snake_len  = 6'd3;
        bus.cand_x     = '0;
        bus.cand_y     = '0;
        for (int j = 0; j < 32; j++) begin
            body_x[j] = 5'd31;
            body_y[j] = 5'd31;
        end
        body_x[0] = 5'd5; body_y[0] = 5'd5;
        body_x[1] = 5'd4; body_y[1] = 5'd5;
        body_x[2] = 5'd3; body_y[2] = 5'd5;
        dflt_x = 5'd10;
        dflt_y = 5'd10;

        repeat (3) cyc();
        chk("rst_apple_x", 32'(bus.apple_x), 32'd8);
        chk("rst_apple_y", 32'(bus.apple_y), 32'd16);
        chk("rst_ready", 32'(bus.apple_ready), 32'd0);
        chk("rst_eaten", 32'(bus.apple_eaten), 32'd0);
        chk("rst_fail", 32'(bus.place_fail), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_valid", 32'(bus.apple_valid), 32'd0);
        chk("rst_conflict", 32'(bus.apple_conflict), 32'd0);
        rst = 1'b1;
        cyc();
        chk("idle_valid", 32'(bus.apple_valid), 32'd0);

        // First placement: clear candidate, ready at REQ+6.
        push(5'd8, 5'd16);
        c0 = n_conf;
        start_game();
        chk("t1_req_valid", 32'(bus.apple_valid), 32'd1);
        cyc();
        chk("t1_wait_valid", 32'(bus.apple_valid), 32'd0);
        repeat (4) cyc();
        chk("t1_ready_c5", 32'(bus.apple_ready), 32'd0);
        cyc();
        chk("t1_ready_c6", 32'(bus.apple_ready), 32'd1);
        chk("t1_apple_x", 32'(bus.apple_x), 32'd8);
        chk("t1_apple_y", 32'(bus.apple_y), 32'd16);
        chk("t1_no_conf", 32'(n_conf - c0), 32'd0);

        // Candidate on segment 2 conflicts at k=3; retry (20,3) is clear.
        push(5'd3, 5'd5);
        push(5'd20, 5'd3);
        c0 = n_conf;
        v0 = n_valid;
        start_game();
        repeat (4) cyc();
        chk("t2_conf_k2", 32'(bus.apple_conflict), 32'd0);
        cyc();
        chk("t2_conf_k3", 32'(bus.apple_conflict), 32'd1);
        chk("t2_valid_k3", 32'(bus.apple_valid), 32'd0);
        repeat (5) cyc();
        chk("t2_ready_c10", 32'(bus.apple_ready), 32'd0);
        cyc();
        chk("t2_ready_c11", 32'(bus.apple_ready), 32'd1);
        chk("t2_apple_x", 32'(bus.apple_x), 32'd20);
        chk("t2_apple_y", 32'(bus.apple_y), 32'd3);
        chk("t2_conf_cnt", 32'(n_conf - c0), 32'd1);
        chk("t2_valid_cnt", 32'(n_valid - v0), 32'd1);

        // Eat detection needs both tick and head match.
        bus.head_x = 5'd20;
        bus.head_y = 5'd3;
        bus.tick   = 1'b0;
        cyc();
        chk("t3_notick_eaten", 32'(bus.apple_eaten), 32'd0);
        chk("t3_notick_ready", 32'(bus.apple_ready), 32'd1);
        bus.head_y = 5'd4;
        bus.tick   = 1'b1;
        cyc();
        chk("t3_miss_eaten", 32'(bus.apple_eaten), 32'd0);
        chk("t3_miss_ready", 32'(bus.apple_ready), 32'd1);
        bus.head_y = 5'd3;
        cyc();
        chk("t3_eaten", 32'(bus.apple_eaten), 32'd1);
        chk("t3_score", 32'(bus.score), 32'd1);
        chk("t3_ready_drop", 32'(bus.apple_ready), 32'd0);
        chk("t3_valid_next", 32'(bus.apple_valid), 32'd1);
        bus.tick   = 1'b0;
        bus.head_x = '0;
        bus.head_y = '0;
        cyc();
        chk("t3_eaten_clr", 32'(bus.apple_eaten), 32'd0);
        wait_ready("t3_replace", 20);
        chk("t3_apple_x", 32'(bus.apple_x), 32'd10);

        // Generator always hits segment 1: 15 retries then place_fail.
        dflt_x = 5'd4;
        dflt_y = 5'd5;
        c0 = n_conf;
        start_game();
        i = 0;
        while (bus.place_fail !== 1'b1 && i < 200) begin
            cyc();
            i++;
        end
        chk("t4_fail", 32'(bus.place_fail), 32'd1);
        chk("t4_conf_cnt", 32'(n_conf - c0), 32'd15);
        chk("t4_ready", 32'(bus.apple_ready), 32'd0);
        v0 = n_valid;
        c0 = n_conf;
        repeat (3) cyc();
        chk("t4_idle_valid", 32'(n_valid - v0), 32'd0);
        chk("t4_idle_conf", 32'(n_conf - c0), 32'd0);
        chk("t4_fail_sticky", 32'(bus.place_fail), 32'd1);
        dflt_x = 5'd10;
        dflt_y = 5'd10;
        start_game();
        chk("t4_fail_clr", 32'(bus.place_fail), 32'd0);
        chk("t4_restart_valid", 32'(bus.apple_valid), 32'd1);
        wait_ready("t4_replace", 20);

        // Score saturates at 255.
        bus.head_x = 5'd10;
        bus.head_y = 5'd10;
        bus.tick   = 1'b1;
        eats = 0;
        i = 0;
        while (eats < 255 && i < 6000) begin
            cyc();
            if (bus.apple_eaten === 1'b1) eats++;
            i++;
        end
        chk("t5_eats255", 32'(eats), 32'd255);
        chk("t5_score255", 32'(bus.score), 32'd255);
        i = 0;
        while (eats < 256 && i < 40) begin
            cyc();
            if (bus.apple_eaten === 1'b1) eats++;
            i++;
        end
        chk("t5_eats256", 32'(eats), 32'd256);
        chk("t5_score_sat", 32'(bus.score), 32'd255);
        bus.tick   = 1'b0;
        bus.head_x = '0;
        bus.head_y = '0;
        wait_ready("t5_replace", 20);

        // game_over from PLACED: apple and score hold.
        bus.game_over = 1'b1;
        cyc();
        bus.game_over = 1'b0;
        chk("t5_go_ready", 32'(bus.apple_ready), 32'd0);
        chk("t5_go_score", 32'(bus.score), 32'd255);
        chk("t5_go_apple_x", 32'(bus.apple_x), 32'd10);
        cyc();
        chk("t5_go_valid", 32'(bus.apple_valid), 32'd0);

        // game_over + game_start on the would-be conflict cycle.
        push(5'd3, 5'd5);
        start_game();
        repeat (5) cyc();
        chk("t6_pre_conf", 32'(bus.apple_conflict), 32'd1);
        c0 = n_conf;
        v0 = n_valid;
        bus.game_over  = 1'b1;
        bus.game_start = 1'b1;
        #1;
        chk("t6_conf_masked", 32'(bus.apple_conflict), 32'd0);
        chk("t6_valid_masked", 32'(bus.apple_valid), 32'd0);
        cyc();
        bus.game_over  = 1'b0;
        bus.game_start = 1'b0;
        chk("t6_ready", 32'(bus.apple_ready), 32'd0);
        repeat (3) cyc();
        chk("t6_conf_cnt", 32'(n_conf - c0), 32'd0);
        chk("t6_valid_cnt", 32'(n_valid - v0), 32'd0);

        // Asynchronous reset while PLACED.
        push(5'd20, 5'd3);
        start_game();
        wait_ready("t7_place", 20);
        chk("t7_apple_x", 32'(bus.apple_x), 32'd20);
        bus.head_x = 5'd20;
        bus.head_y = 5'd3;
        bus.tick   = 1'b1;
        cyc();
        chk("t7_score", 32'(bus.score), 32'd1);
        bus.tick   = 1'b0;
        bus.head_x = '0;
        bus.head_y = '0;
        wait_ready("t7_replace", 20);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_rst_apple_x", 32'(bus.apple_x), 32'd8);
        chk("t7_rst_apple_y", 32'(bus.apple_y), 32'd16);
        chk("t7_rst_score", 32'(bus.score), 32'd0);
        chk("t7_rst_ready", 32'(bus.apple_ready), 32'd0);
        cyc();
        v0 = n_valid;
        c0 = n_conf;
        rst = 1'b1;
        #1;
        chk("t7_rel_valid", 32'(bus.apple_valid), 32'd0);
        repeat (3) cyc();
        chk("t7_rel_valid_cnt", 32'(n_valid - v0), 32'd0);
        chk("t7_rel_conf_cnt", 32'(n_conf - c0), 32'd0);
        chk("t7_rel_eaten", 32'(bus.apple_eaten), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
